// File: rtl/cim_cmd_unit.sv
// CIM command unit: FIFO-queued CPU commands issued one at a time to BANKS CIM macros, read data written back.
// CIM_VALID two cycles after acceptance into an idle unit; REQ_READY is low while the FIFO is full or in reset.

module cim_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         core_clk,
  input  logic         arst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW:0]  wp_q, wp_d, rp_q, rp_d;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q[PW-1:0]] = din;
    wp_d = wp_q + {{PW{1'b0}}, push};
    rp_d = rp_q + {{PW{1'b0}}, pop};
  end

  always_ff @(posedge core_clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Extra pointer bit tells full from empty when the indices match.
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign dout  = mem_q[rp_q[PW-1:0]];
endmodule

module cim_cmd_unit #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 4,
  parameter int BANKS = 2,
  parameter int TMO   = 255
) (
  input  logic                CLK,
  input  logic                RESN,
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic [2:0]          REQ_OP,
  input  logic [DW-1:0]       REQ_RS1,
  input  logic [DW-1:0]       REQ_RS2,
  input  logic [4:0]          REQ_RD,
  output logic [BANKS-1:0]    CIM_VALID,
  input  logic [BANKS-1:0]    CIM_READY,
  output logic                CIM_WRITE,
  output logic                CIM_COMP,
  output logic                CIM_PSUM,
  output logic                CIM_RESET,
  output logic [3:0]          CIM_OREG,
  output logic [AW-1:0]       CIM_ADDR,
  output logic [DW-1:0]       CIM_DATA,
  input  logic [BANKS-1:0]    CIM_RVALID,
  input  logic [BANKS*DW-1:0] CIM_RDATA,
  output logic                WB_VALID,
  input  logic                WB_READY,
  output logic [4:0]          WB_RD,
  output logic [DW-1:0]       WB_DATA,
  output logic                BUSY,
  output logic [1:0]          ERR,
  input  logic                ERR_CLR
);
  localparam int BW  = (BANKS > 1) ? $clog2(BANKS) : 0;
  localparam int BWI = (BW > 0) ? BW : 1;
  localparam int TCW = $clog2(TMO + 1);

  localparam logic [2:0] OP_WR     = 3'd0;
  localparam logic [2:0] OP_COMP   = 3'd1;
  localparam logic [2:0] OP_RD     = 3'd2;
  localparam logic [2:0] OP_REGRD  = 3'd3;
  localparam logic [2:0] OP_REGRST = 3'd4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, WB} state_t;

  typedef struct packed {
    logic [2:0]    op;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic [4:0]    rd;
  } cmd_t;

  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [BANKS-1:0]  pend_q, pend_d;
  logic [BWI-1:0]    bank_q, bank_d;
  logic [TCW-1:0]    tmo_q, tmo_d;
  logic [DW-1:0]     data_q, data_d;
  logic [1:0]        err_q, err_d;
  logic              rdy_q, rdy_d;

  cmd_t              req_dat;
  cmd_t              fifo_dat;
  logic              fifo_full, fifo_empty, push, pop;
  logic [DW-1:0]     rdata_bank [BANKS];

  function automatic logic [BWI-1:0] bank_of(input cmd_t c);
    logic [BWI-1:0] b;
    b = '0;
    case (c.op)
      OP_WR, OP_COMP: b = c.rs2[BWI+1:2];
      OP_RD:          b = c.rs1[BWI+1:2];
      OP_REGRD:       b = c.rs2[BWI-1:0];
      default:        b = '0;
    endcase
    if (BANKS == 1) b = '0;
    return b;
  endfunction

  assign req_dat   = {REQ_OP, REQ_RS1, REQ_RS2, REQ_RD};
  assign REQ_READY = rdy_q && !fifo_full;
  assign push      = REQ_VALID && REQ_READY;

  cim_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
    .core_clk (CLK),
    .arst_n   (RESN),
    .push     (push),
    .din      (req_dat),
    .pop      (pop),
    .dout     (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    for (int b = 0; b < BANKS; b++) rdata_bank[b] = CIM_RDATA[b*DW +: DW];
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    pend_d  = pend_q;
    bank_d  = bank_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    rdy_d   = 1'b1;
    err_d   = ERR_CLR ? 2'b00 : err_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop    = 1'b1;
          cmd_d  = fifo_dat;
          bank_d = bank_of(fifo_dat);
          if (fifo_dat.op > OP_REGRST) begin
            err_d[0] = 1'b1;
          end else begin
            state_d = ISSUE;
            pend_d  = (fifo_dat.op == OP_REGRST) ? '1 : (BANKS'(1) << bank_of(fifo_dat));
          end
        end
      end
      ISSUE: begin
        // Each bank drops out of the request set as it accepts.
        pend_d = pend_q & ~CIM_READY;
        if (pend_d == '0) begin
          tmo_d   = '0;
          state_d = (cmd_q.op == OP_RD || cmd_q.op == OP_REGRD) ? WAIT_RSP : IDLE;
        end
      end
      WAIT_RSP: begin
        if (CIM_RVALID[bank_q]) begin
          data_d  = rdata_bank[bank_q];
          state_d = (cmd_q.rd != 5'd0) ? WB : IDLE;
        end else if (tmo_q == TCW'(TMO - 1)) begin
          err_d[1] = 1'b1;
          data_d   = '1;
          state_d  = (cmd_q.rd != 5'd0) ? WB : IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WB: begin
        if (WB_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      pend_q  <= '0;
      bank_q  <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      err_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      pend_q  <= pend_d;
      bank_q  <= bank_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    CIM_VALID = '0;
    CIM_WRITE = 1'b0;
    CIM_COMP  = 1'b0;
    CIM_PSUM  = 1'b0;
    CIM_RESET = 1'b0;
    CIM_OREG  = 4'd0;
    CIM_ADDR  = '0;
    CIM_DATA  = '0;
    if (state_q == ISSUE) begin
      CIM_VALID = pend_q;
      case (cmd_q.op)
        OP_WR: begin
          CIM_WRITE = 1'b1;
          CIM_ADDR  = AW'(cmd_q.rs2);
          CIM_DATA  = cmd_q.rs1;
        end
        OP_COMP: begin
          CIM_COMP = 1'b1;
          CIM_PSUM = 1'b1;
          CIM_ADDR = AW'(cmd_q.rs2);
          CIM_DATA = cmd_q.rs1;
        end
        OP_RD: CIM_ADDR = AW'(cmd_q.rs1);
        OP_REGRD: begin
          CIM_COMP = 1'b1;
          CIM_OREG = cmd_q.rs1[3:0];
        end
        OP_REGRST: begin
          CIM_COMP  = 1'b1;
          CIM_RESET = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign WB_VALID = (state_q == WB);
  assign WB_RD    = (state_q == WB) ? cmd_q.rd : 5'd0;
  assign WB_DATA  = (state_q == WB) ? data_q : '0;
  assign BUSY     = !fifo_empty || (state_q != IDLE);
  assign ERR      = err_q;
endmodule
